// File: rtl/sseg_scan_ctrl.sv
// Self-timed N-digit common-anode 7-segment scanner with WIN/LOSE messages.
// Define SSEG_BLINK_EN to blink the WIN/LOSE message every BLINK_FRAMES frames.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [1:0]                    mode,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_nd
    $error("NUM_DIGITS must be 2..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be >= 1");
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  tick_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  logic                  step, wrap;
  logic                  msg, blink_dark, dark;
  logic [3:0]            val;

  assign step = cnt_q == CW'(REFRESH_DIV - 1);
  assign wrap = step && (idx_q == IW'(NUM_DIGITS - 1));
  assign msg  = (mode == 2'b01) || (mode == 2'b10);

  always_comb begin
    cnt_d = step ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (step) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Count on the wrap edge itself so the phase flips exactly at a frame start.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_dark = phase_q & msg;
`else
  assign blink_dark = 1'b0;
`endif

  assign dark = blank_mask[idx_q] | (mode == 2'b11) | blink_dark;

  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
    dp_d  = 1'b1;
    val   = digits[4*idx_q +: 4];
    unique case (1'b1)
      mode == 2'b01: val = 4'hA;
      mode == 2'b10: val = 4'hF;
      default:       dp_d = ~dp_mask[idx_q];
    endcase
    if (dark) begin
      dp_d = 1'b1;
    end else begin
      seg_d = hex7(val);
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      seg_q  <= 7'h7F;
      an_q   <= '1;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      tick_q <= wrap;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (4 digits, 4-cycle refresh).
// Blink scenario is compiled only with SSEG_BLINK_EN.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h1A80;
  logic [3:0]  dp_mask = 4'b0100;
  logic [3:0]  blank_mask = 4'b0000;
  logic [1:0]  mode = 2'b00;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  logic [3:0] EXP_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] EXP_SEG [4] = '{7'h40, 7'h00, 7'h08, 7'h79};

  sseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blank_mask(blank_mask),
    .mode      (mode),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic restart();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step_edge();
    step_edge();
    checks++;
    if (an !== 4'hF) begin
      errors++; $display("FAIL rst_an got %b exp 1111", an);
    end
    checks++;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL rst_seg got %h exp 7f", seg);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++; $display("FAIL rst_dp got %b exp 1", dp);
    end
    checks++;
    if (digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_idx got %0d/%b exp 0/0", digit_idx, frame_tick);
    end
    rst_n = 1'b1;
    step_edge();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      errors++; $display("FAIL rel_first got %b/%h exp 1110/40", an, seg);
    end
    step_edge();
    step_edge();
    checks++;
    if (digit_idx !== 2'd0) begin
      errors++; $display("FAIL rel_idx3 got %0d exp 0", digit_idx);
    end
    step_edge();
    checks++;
    if (digit_idx !== 2'd1) begin
      errors++; $display("FAIL rel_idx4 got %0d exp 1", digit_idx);
    end
  endtask

  task automatic test_scan();
    int k;
    restart();
    for (int n = 1; n <= 32; n++) begin
      step_edge();
      k = ((n - 1) / 4) % 4;
      checks++;
      if (an !== EXP_AN[k]) begin
        errors++; $display("FAIL scan_an n=%0d got %b exp %b", n, an, EXP_AN[k]);
      end
      checks++;
      if (seg !== EXP_SEG[k]) begin
        errors++; $display("FAIL scan_seg n=%0d got %h exp %h", n, seg, EXP_SEG[k]);
      end
      checks++;
      if (dp !== (k != 2)) begin
        errors++; $display("FAIL scan_dp n=%0d got %b exp %b", n, dp, k != 2);
      end
      checks++;
      if (digit_idx !== 2'((n / 4) % 4)) begin
        errors++;
        $display("FAIL scan_idx n=%0d got %0d exp %0d", n, digit_idx, (n / 4) % 4);
      end
      checks++;
      if (frame_tick !== (n % 16 == 0)) begin
        errors++;
        $display("FAIL scan_tick n=%0d got %b exp %b", n, frame_tick, n % 16 == 0);
      end
    end
  endtask

  task automatic test_messages();
    int k;
    logic [6:0] es;
    mode = 2'b01;
    restart();
    for (int n = 1; n <= 16; n++) begin
      if (n == 7) mode = 2'b10;
      step_edge();
      k  = ((n - 1) / 4) % 4;
      es = (n >= 7) ? 7'h0E : 7'h08;
      checks++;
      if (seg !== es || dp !== 1'b1) begin
        errors++; $display("FAIL msg_seg n=%0d got %h/%b exp %h/1", n, seg, dp, es);
      end
      checks++;
      if (an !== EXP_AN[k]) begin
        errors++; $display("FAIL msg_an n=%0d got %b exp %b", n, an, EXP_AN[k]);
      end
      checks++;
      if (digit_idx !== 2'((n / 4) % 4)) begin
        errors++; $display("FAIL msg_idx n=%0d got %0d", n, digit_idx);
      end
    end
    mode = 2'b00;
  endtask

  task automatic test_blanking();
    int k;
    logic [3:0] ea;
    logic [6:0] es;
    blank_mask = 4'b0010;
    mode = 2'b01;
    restart();
    for (int n = 1; n <= 24; n++) begin
      if (n == 17) mode = 2'b11;
      step_edge();
      k  = ((n - 1) / 4) % 4;
      ea = (n > 16 || k == 1) ? 4'hF : EXP_AN[k];
      es = (n > 16 || k == 1) ? 7'h7F : 7'h08;
      checks++;
      if (an !== ea || seg !== es || dp !== 1'b1) begin
        errors++;
        $display("FAIL blank n=%0d got %b/%h/%b exp %b/%h/1", n, an, seg, dp, ea, es);
      end
    end
    blank_mask = 4'b0000;
    mode = 2'b00;
  endtask

  task automatic test_async_reset();
    restart();
    for (int n = 1; n <= 10; n++) step_edge();
    checks++;
    if (digit_idx !== 2'd2 || an !== 4'b1011) begin
      errors++; $display("FAIL ar_pre got %0d/%b exp 2/1011", digit_idx, an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++; $display("FAIL ar_out got %b/%h/%b exp 1111/7f/1", an, seg, dp);
    end
    checks++;
    if (digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
      errors++; $display("FAIL ar_idx got %0d/%b exp 0/0", digit_idx, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step_edge();
      checks++;
      if (an !== EXP_AN[(n - 1) / 4] || digit_idx !== 2'(n / 4)) begin
        errors++;
        $display("FAIL ar_restart n=%0d got %b/%0d exp %b/%0d",
                 n, an, digit_idx, EXP_AN[(n - 1) / 4], n / 4);
      end
    end
  endtask

`ifdef SSEG_BLINK_EN
  task automatic test_blink();
    int k;
    logic drk;
    logic [3:0] ea;
    mode = 2'b10;
    restart();
    for (int n = 1; n <= 128; n++) begin
      step_edge();
      k   = ((n - 1) / 4) % 4;
      drk = (((n - 1) / 32) % 2) == 1;
      ea  = drk ? 4'hF : EXP_AN[k];
      checks++;
      if (an !== ea) begin
        errors++; $display("FAIL blink_an n=%0d got %b exp %b", n, an, ea);
      end
    end
    mode = 2'b00;
    restart();
    for (int n = 1; n <= 64; n++) begin
      step_edge();
      k = ((n - 1) / 4) % 4;
      checks++;
      if (an !== EXP_AN[k]) begin
        errors++; $display("FAIL blink_norm n=%0d got %b exp %b", n, an, EXP_AN[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_messages();
    test_blanking();
    test_async_reset();
`ifdef SSEG_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
